pci_target_param: RTL and testbench
===================================

Name: pci_target_param

Overview:
- Parametrised PCI-style target device; successor to the fixed 3-word target.
- Decodes a word-address window, accepts memory read/write bursts over multiplexed AD, and honours active-low byte enables.
- Inserts target wait states on request.
- At the end of its window, either disconnects with STOP or wraps (mode parameter).
- Sits on the shared PCI bus model beside other targets and the master/testbench.

Parameters:
- DEPTH, 8, number of 32-bit words of target memory (>=2).
- BASE_ADDR, 32'h0000_0000, first word address claimed; window is BASE_ADDR..BASE_ADDR+DEPTH-1.
- WRAP_EN, 0, 1 = pointer wraps to 0 at end of window; 0 = disconnect with STOP.
- CNT_W, 8, width of the completed-data-phase counter.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- FRAME  input  1  active-low; master transaction framing.
- IRDY  input  1  active-low; initiator ready.
- C_BE  input  4  command in address phase; active-low byte enables in data phases.
- AD  inout  32  address/data; driven only during read data phases.
- ntrdy  input  1  active-high request to insert target wait states.
- DEVSEL  output  1  active-low device select.
- TRDY  output  1  active-low target ready.
- STOP  output  1  active-low disconnect request.
- xfer_cnt  output  CNT_W  completed data phases of the current or last transaction; saturates at max.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset: DEVSEL=1, TRDY=1, STOP=1, AD released (high-Z), xfer_cnt=0, FSM to IDLE. Memory contents are preserved. Reset mid-transaction aborts the transaction at that edge.
- Commands: 4'b0110 = memory read, 4'b0111 = memory write; all others are ignored and the target stays in IDLE.
- Hit condition: FRAME=0 in IDLE, (AD - BASE_ADDR) < DEPTH (unsigned), and supported command. On hit: ptr = AD - BASE_ADDR, xfer_cnt cleared.
- FSM states: IDLE, WR, RD_TA, RD, DISC, DONE.
- IDLE -> WR on write hit: next cycle DEVSEL=0, and TRDY=0 unless ntrdy=1.
- IDLE -> RD_TA on read hit: next cycle DEVSEL=0, TRDY=1, AD not driven (turnaround).
- RD_TA -> RD: AD driven with mem[ptr]; TRDY=0 unless ntrdy=1.
- Data transfer occurs on any posedge with IRDY=0 and TRDY=0.
- Write transfer: byte i of mem[ptr] written iff C_BE[i]=0.
- Read transfer: the next word mem[ptr+1] is presented the following cycle.
- Every transfer: ptr increments, xfer_cnt increments.
- Wait states, target side: ntrdy sampled high -> TRDY=1 next cycle; ptr and AD held; no transfer.
- Wait states, initiator side: IRDY=1 with TRDY=0 -> TRDY held 0, data held, no transfer.
- Last phase: transfer with FRAME=1 -> DONE next cycle: TRDY=1, DEVSEL=1, STOP=1, AD released; then IDLE.
- End of window, WRAP_EN=0: on the transfer that completes word DEPTH-1 while FRAME=0, the next cycle enters DISC with STOP=0, TRDY=1, DEVSEL=0.
- DISC: held until FRAME=1, then DONE (STOP=1, DEVSEL=1).
- End of window, WRAP_EN=1: ptr wraps to 0; the burst continues without STOP.
- Burst starting on the last word with WRAP_EN=0: one transfer, then DISC.
- Master abort: FRAME=1 and IRDY=1 while DEVSEL=0 with no transfer pending -> DONE.
- Simultaneous ntrdy=1 and end-of-window on the same transfer: the disconnect takes precedence; no wait state is inserted.
- AD is never driven outside RD; only one driver per cycle.

Decomposition:
- Shared package/include pci_pkg: command codes (CMD_MEM_RD=4'b0110, CMD_MEM_WR=4'b0111), FSM state encodings, and the byte-enable-active-low convention.
- Sub-module pci_target_mem: DEPTH x 32 register file.
  - Synchronous write with 4 per-byte write enables.
  - Combinational read port.

Test Plan:
- Write burst: BASE_ADDR=4, DEPTH=8; write at addr 4, data 11111111/22222222/33333333, C_BE=0000 -> mem[0..2] updated; DEVSEL and TRDY released the cycle after the third transfer; xfer_cnt=3.
- Byte enables: write AABBCCDD to mem[1] (pre-set 00000000) with C_BE=1010 -> mem[1]=00BB00DD.
- Read burst with waits: read 3 words from addr 4 after the write burst; ntrdy high for 2 cycles on the 2nd phase; IRDY high for 1 cycle on the 3rd -> turnaround cycle present; data 11111111, 22222222, 33333333 in order; TRDY=1 during ntrdy; xfer_cnt=3.
- Disconnect, WRAP_EN=0: read from addr 10 (ptr 6) with a 4-phase burst -> words 6 and 7 transfer, then STOP=0 until FRAME=1; xfer_cnt=2.
- Wrap, WRAP_EN=1: same stimulus -> words 6, 7, 0, 1 transferred; STOP stays 1 throughout.
- Miss, unsupported command, and reset: address 3 (miss) or command 4'b0010 -> DEVSEL stays 1. Reset asserted mid read burst -> next edge all outputs 1, AD high-Z; memory unchanged.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared PCI target definitions: command codes, FSM encodings, byte-enable helper.
package pci_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned BE_W  = 4;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR    = 3'd1;
    localparam logic [2:0] ST_RD_TA = 3'd2;
    localparam logic [2:0] ST_RD    = 3'd3;
    localparam logic [2:0] ST_DISC  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Byte enables on the bus are active-low; memory write enables are active-high.
    function automatic logic [BE_W-1:0] be_to_we(input logic [BE_W-1:0] c_be);
        return ~c_be;
    endfunction

endpackage

// File: rtl/pci_target_mem.sv
// DEPTH x 32 register file: synchronous byte-masked write, combinational read.
module pci_target_mem
    import pci_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [BE_W-1:0]  byte_we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [BUS_W-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [BUS_W-1:0] rdata
);

    logic [BUS_W-1:0] mem [DEPTH];

    // Per-byte write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (byte_we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pci_target_param.sv
// Parametrised PCI memory target: window decode, bursts, wait states, STOP or wrap at window end.
module pci_target_param
    import pci_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          WRAP_EN   = 1'b0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FRAME,
    input  logic             IRDY,
    input  logic [3:0]       C_BE,
    inout  wire  [31:0]      AD,
    input  logic             ntrdy,
    output logic             DEVSEL,
    output logic             TRDY,
    output logic             STOP,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             devsel_q, devsel_d;
    logic             trdy_q, trdy_d;
    logic             stop_q, stop_d;
    logic             ad_oe_q;
    logic [BUS_W-1:0] ad_q, rdata, offset;
    logic             hit, xfer, last, mem_we;

    assign offset  = AD - BASE_ADDR;
    assign hit     = (offset < BUS_W'(DEPTH)) && ((C_BE == CMD_MEM_RD) || (C_BE == CMD_MEM_WR));
    assign xfer    = !IRDY && !trdy_q && ((state_q == ST_WR) || (state_q == ST_RD));
    assign last    = (ptr_q == PTR_W'(DEPTH - 1));
    assign ptr_inc = last ? '0 : ptr_q + PTR_W'(1);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign mem_we  = (state_q == ST_WR) && xfer && !reset;

    pci_target_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .byte_we (be_to_we(C_BE)),
        .waddr   (ptr_q),
        .wdata   (AD),
        .raddr   (ptr_d),
        .rdata   (rdata)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        devsel_d = devsel_q;
        trdy_d   = trdy_q;
        stop_d   = stop_q;
        case (state_q)
            ST_IDLE: begin
                devsel_d = 1'b1;
                trdy_d   = 1'b1;
                stop_d   = 1'b1;
                if (!FRAME && hit) begin
                    ptr_d    = PTR_W'(offset);
                    cnt_d    = '0;
                    devsel_d = 1'b0;
                    if (C_BE == CMD_MEM_WR) begin
                        state_d = ST_WR;
                        trdy_d  = ntrdy;
                    end else begin
                        state_d = ST_RD_TA;
                    end
                end
            end
            ST_RD_TA: begin
                if (FRAME && IRDY) begin
                    state_d  = ST_DONE;
                    devsel_d = 1'b1;
                    trdy_d   = 1'b1;
                end else begin
                    state_d = ST_RD;
                    trdy_d  = ntrdy;
                end
            end
            ST_WR, ST_RD: begin
                if (xfer) begin
                    ptr_d = ptr_inc;
                    cnt_d = cnt_inc;
                    if (FRAME) begin
                        state_d  = ST_DONE;
                        devsel_d = 1'b1;
                        trdy_d   = 1'b1;
                    end else if (last && !WRAP_EN) begin
                        // Window exhausted: disconnect wins over any wait-state request.
                        state_d = ST_DISC;
                        trdy_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        trdy_d = ntrdy;
                    end
                end else if (FRAME && IRDY) begin
                    state_d  = ST_DONE;
                    devsel_d = 1'b1;
                    trdy_d   = 1'b1;
                end else if (trdy_q) begin
                    trdy_d = ntrdy;
                end
            end
            ST_DISC: begin
                if (FRAME) begin
                    state_d  = ST_DONE;
                    devsel_d = 1'b1;
                    stop_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                devsel_d = 1'b1;
                trdy_d   = 1'b1;
                stop_d   = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                devsel_d = 1'b1;
                trdy_d   = 1'b1;
                stop_d   = 1'b1;
            end
        endcase
    end

    // State, control outputs and read-data register; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            devsel_q <= 1'b1;
            trdy_q   <= 1'b1;
            stop_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            devsel_q <= devsel_d;
            trdy_q   <= trdy_d;
            stop_q   <= stop_d;
            ad_oe_q  <= (state_d == ST_RD);
            ad_q     <= rdata;
        end
    end

    assign AD       = ad_oe_q ? ad_q : 'z;
    assign DEVSEL   = devsel_q;
    assign TRDY     = trdy_q;
    assign STOP     = stop_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_pci_target_param.sv
// Directed bench: two targets (no-wrap / wrap) share the master stimulus on separate AD nets.
module tb_pci_target_param;

    logic        clk = 1'b0;
    logic        reset, FRAME, IRDY, ntrdy;
    logic [3:0]  C_BE;
    logic [31:0] ad_drv;
    logic        tb_oe0, tb_oe1;
    wire  [31:0] ad0, ad1;
    wire         devsel0, trdy0, stop0, devsel1, trdy1, stop1;
    wire  [7:0]  cnt0, cnt1;
    logic [31:0] wbuf [4];
    int          checks = 0;
    int          failures = 0;

    assign ad0 = tb_oe0 ? ad_drv : 'z;
    assign ad1 = tb_oe1 ? ad_drv : 'z;

    always #5 clk = ~clk;

    pci_target_param #(.DEPTH(8), .BASE_ADDR(32'h4), .WRAP_EN(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .FRAME(FRAME), .IRDY(IRDY), .C_BE(C_BE), .AD(ad0),
        .ntrdy(ntrdy), .DEVSEL(devsel0), .TRDY(trdy0), .STOP(stop0), .xfer_cnt(cnt0));

    pci_target_param #(.DEPTH(8), .BASE_ADDR(32'h4), .WRAP_EN(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .FRAME(FRAME), .IRDY(IRDY), .C_BE(C_BE), .AD(ad1),
        .ntrdy(ntrdy), .DEVSEL(devsel1), .TRDY(trdy1), .STOP(stop1), .xfer_cnt(cnt1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        FRAME = 1'b1; IRDY = 1'b1; ntrdy = 1'b0; C_BE = 4'hF;
        ad_drv = 32'h0; tb_oe0 = 1'b1; tb_oe1 = 1'b1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
        FRAME = 1'b0; IRDY = 1'b1; C_BE = cmd; ad_drv = a; tb_oe0 = 1'b1; tb_oe1 = 1'b1;
    endtask

    // Setup-only write burst of n words from wbuf, no wait states.
    task automatic bus_write(input logic [31:0] a, input int n, input logic [3:0] be);
        addr_phase(a, 4'b0111);
        tick();
        for (int i = 0; i < n; i++) begin
            ad_drv = wbuf[i]; C_BE = be; IRDY = 1'b0; FRAME = (i == n - 1);
            tick();
        end
        idle_bus();
        tick();
    endtask

    task automatic test_reset;
        idle_bus();
        reset = 1'b1;
        tick(); tick();
        checks++; if (devsel0 !== 1'b1) begin failures++; $display("FAIL rst_devsel got=%b exp=1", devsel0); end
        checks++; if (trdy0 !== 1'b1)   begin failures++; $display("FAIL rst_trdy got=%b exp=1", trdy0); end
        checks++; if (stop0 !== 1'b1)   begin failures++; $display("FAIL rst_stop got=%b exp=1", stop0); end
        checks++; if (cnt0 !== 8'd0)    begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt0); end
        checks++; if (ad0 !== 32'h0)    begin failures++; $display("FAIL rst_ad_released got=%h exp=0", ad0); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_burst;
        addr_phase(32'h4, 4'b0111);
        tick();
        checks++; if (devsel0 !== 1'b0 || trdy0 !== 1'b0) begin failures++; $display("FAIL wr_claim got=%b%b exp=00", devsel0, trdy0); end
        ad_drv = 32'h1111_1111; C_BE = 4'b0000; IRDY = 1'b0;
        tick();
        checks++; if (cnt0 !== 8'd1) begin failures++; $display("FAIL wr_cnt1 got=%0d exp=1", cnt0); end
        ad_drv = 32'h2222_2222;
        tick();
        ad_drv = 32'h3333_3333; FRAME = 1'b1;
        tick();
        checks++; if (devsel0 !== 1'b1 || trdy0 !== 1'b1) begin failures++; $display("FAIL wr_release got=%b%b exp=11", devsel0, trdy0); end
        checks++; if (cnt0 !== 8'd3) begin failures++; $display("FAIL wr_cnt3 got=%0d exp=3", cnt0); end
        idle_bus();
        tick();
    endtask

    task automatic test_read_waits;
        addr_phase(32'h4, 4'b0110);
        tick();
        checks++; if (devsel0 !== 1'b0 || trdy0 !== 1'b1) begin failures++; $display("FAIL rd_ta_ctl got=%b%b exp=01", devsel0, trdy0); end
        checks++; if (ad0 !== 32'h4) begin failures++; $display("FAIL rd_ta_ad got=%h exp=00000004", ad0); end
        tb_oe0 = 1'b0; tb_oe1 = 1'b0; IRDY = 1'b0; C_BE = 4'b0000;
        tick();
        checks++; if (trdy0 !== 1'b0 || ad0 !== 32'h1111_1111) begin failures++; $display("FAIL rd_d0 got=%b %h exp=0 11111111", trdy0, ad0); end
        ntrdy = 1'b1;
        tick();
        checks++; if (trdy0 !== 1'b1 || ad0 !== 32'h2222_2222) begin failures++; $display("FAIL rd_wait1 got=%b %h exp=1 22222222", trdy0, ad0); end
        tick();
        checks++; if (trdy0 !== 1'b1 || ad0 !== 32'h2222_2222 || cnt0 !== 8'd1) begin failures++; $display("FAIL rd_wait2 got=%b %h %0d exp=1 22222222 1", trdy0, ad0, cnt0); end
        ntrdy = 1'b0;
        tick();
        checks++; if (trdy0 !== 1'b0 || ad0 !== 32'h2222_2222) begin failures++; $display("FAIL rd_d1 got=%b %h exp=0 22222222", trdy0, ad0); end
        tick();
        checks++; if (ad0 !== 32'h3333_3333 || cnt0 !== 8'd2) begin failures++; $display("FAIL rd_d2 got=%h %0d exp=33333333 2", ad0, cnt0); end
        IRDY = 1'b1;
        tick();
        checks++; if (trdy0 !== 1'b0 || ad0 !== 32'h3333_3333 || cnt0 !== 8'd2) begin failures++; $display("FAIL rd_irdy_wait got=%b %h %0d exp=0 33333333 2", trdy0, ad0, cnt0); end
        IRDY = 1'b0; FRAME = 1'b1;
        tick();
        checks++; if (devsel0 !== 1'b1 || trdy0 !== 1'b1 || cnt0 !== 8'd3) begin failures++; $display("FAIL rd_done got=%b%b %0d exp=11 3", devsel0, trdy0, cnt0); end
        idle_bus();
        #1;
        checks++; if (ad0 !== 32'h0) begin failures++; $display("FAIL rd_done_ad got=%h exp=0", ad0); end
        tick();
    endtask

    task automatic test_byte_enables;
        wbuf[0] = 32'h0000_0000;
        bus_write(32'h5, 1, 4'b0000);
        wbuf[0] = 32'hAABB_CCDD;
        bus_write(32'h5, 1, 4'b1010);
        addr_phase(32'h5, 4'b0110);
        tick();
        tb_oe0 = 1'b0; tb_oe1 = 1'b0; IRDY = 1'b0; FRAME = 1'b1; C_BE = 4'b0000;
        tick();
        checks++; if (ad0 !== 32'h00BB_00DD) begin failures++; $display("FAIL be_data got=%h exp=00bb00dd", ad0); end
        tick();
        checks++; if (cnt0 !== 8'd1 || devsel0 !== 1'b1) begin failures++; $display("FAIL be_single got=%0d %b exp=1 1", cnt0, devsel0); end
        idle_bus();
        tick();
    endtask

    task automatic test_disc_wrap;
        wbuf[0] = 32'h6666_6666; wbuf[1] = 32'h7777_7777;
        bus_write(32'hA, 2, 4'b0000);
        addr_phase(32'hA, 4'b0110);
        tick();
        tb_oe0 = 1'b0; tb_oe1 = 1'b0; IRDY = 1'b0; C_BE = 4'b0000;
        tick();
        checks++; if (ad0 !== 32'h6666_6666 || ad1 !== 32'h6666_6666) begin failures++; $display("FAIL dw_w6 got=%h %h exp=66666666", ad0, ad1); end
        tick();
        checks++; if (ad0 !== 32'h7777_7777 || ad1 !== 32'h7777_7777) begin failures++; $display("FAIL dw_w7 got=%h %h exp=77777777", ad0, ad1); end
        tick();
        checks++; if (stop0 !== 1'b0 || trdy0 !== 1'b1 || devsel0 !== 1'b0 || cnt0 !== 8'd2) begin failures++; $display("FAIL disc_enter got=%b%b%b %0d exp=011 2", stop0, trdy0, devsel0, cnt0); end
        checks++; if (ad1 !== 32'h1111_1111 || stop1 !== 1'b1) begin failures++; $display("FAIL wrap_w0 got=%h %b exp=11111111 1", ad1, stop1); end
        tb_oe0 = 1'b1; ad_drv = 32'h0;
        #1;
        checks++; if (ad0 !== 32'h0) begin failures++; $display("FAIL disc_ad_released got=%h exp=0", ad0); end
        tick();
        checks++; if (stop0 !== 1'b0 || cnt0 !== 8'd2) begin failures++; $display("FAIL disc_hold got=%b %0d exp=0 2", stop0, cnt0); end
        checks++; if (ad1 !== 32'h00BB_00DD || cnt1 !== 8'd3 || stop1 !== 1'b1) begin failures++; $display("FAIL wrap_w1 got=%h %0d %b exp=00bb00dd 3 1", ad1, cnt1, stop1); end
        FRAME = 1'b1;
        tick();
        checks++; if (stop0 !== 1'b1 || devsel0 !== 1'b1 || cnt0 !== 8'd2) begin failures++; $display("FAIL disc_done got=%b%b %0d exp=11 2", stop0, devsel0, cnt0); end
        checks++; if (devsel1 !== 1'b1 || stop1 !== 1'b1 || cnt1 !== 8'd4) begin failures++; $display("FAIL wrap_done got=%b%b %0d exp=11 4", devsel1, stop1, cnt1); end
        idle_bus();
        tick();
    endtask

    task automatic test_miss;
        addr_phase(32'h3, 4'b0111);
        tick();
        checks++; if (devsel0 !== 1'b1 || devsel1 !== 1'b1) begin failures++; $display("FAIL miss_low got=%b%b exp=11", devsel0, devsel1); end
        idle_bus(); tick();
        addr_phase(32'hC, 4'b0110);
        tick();
        checks++; if (devsel0 !== 1'b1 || trdy0 !== 1'b1) begin failures++; $display("FAIL miss_high got=%b%b exp=11", devsel0, trdy0); end
        idle_bus(); tick();
        addr_phase(32'h4, 4'b0010);
        tick();
        checks++; if (devsel0 !== 1'b1) begin failures++; $display("FAIL bad_cmd got=%b exp=1", devsel0); end
        tick();
        checks++; if (devsel0 !== 1'b1 || ad0 !== 32'h4) begin failures++; $display("FAIL bad_cmd_hold got=%b %h exp=1 00000004", devsel0, ad0); end
        idle_bus(); tick();
    endtask

    task automatic test_reset_mid_burst;
        addr_phase(32'h4, 4'b0110);
        tick();
        tb_oe0 = 1'b0; tb_oe1 = 1'b0; IRDY = 1'b0; C_BE = 4'b0000;
        tick();
        tick();
        checks++; if (cnt0 !== 8'd1 || ad0 !== 32'h00BB_00DD) begin failures++; $display("FAIL rstm_pre got=%0d %h exp=1 00bb00dd", cnt0, ad0); end
        reset = 1'b1;
        tick();
        checks++; if (devsel0 !== 1'b1 || trdy0 !== 1'b1 || stop0 !== 1'b1 || cnt0 !== 8'd0) begin failures++; $display("FAIL rstm_ctl got=%b%b%b %0d exp=111 0", devsel0, trdy0, stop0, cnt0); end
        tb_oe0 = 1'b1; ad_drv = 32'h0;
        #1;
        checks++; if (ad0 !== 32'h0) begin failures++; $display("FAIL rstm_ad got=%h exp=0", ad0); end
        reset = 1'b0;
        idle_bus(); tick();
        addr_phase(32'h4, 4'b0110);
        tick();
        tb_oe0 = 1'b0; tb_oe1 = 1'b0; IRDY = 1'b0; FRAME = 1'b1; C_BE = 4'b0000;
        tick();
        checks++; if (ad0 !== 32'h1111_1111) begin failures++; $display("FAIL rstm_mem got=%h exp=11111111", ad0); end
        tick();
        idle_bus(); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_burst();
        test_read_waits();
        test_byte_enables();
        test_disc_wrap();
        test_miss();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
